axis_frame_checker: RTL and testbench

AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

---
 rtl/axis_chk_pkg.sv | 27 ++
 rtl/axis_ready_osc.sv | 56 +++++
 rtl/axis_frame_checker.sv | 162 ++++++++++++++++
 tb/tb_axis_frame_checker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// ---------------------------------------------------------------------------
// axis_chk_pkg
// Shared definitions for the AXI-Stream frame checker:
//   MARKER_DEFAULT - byte-0 value expected on odd beats
//   ch_state_t     - per-channel frame FSM state
//   rdy_mode_t     - ready generator mode encoding
//   nz4()          - maps a 4-bit count of 0 onto 1
// ---------------------------------------------------------------------------
package axis_chk_pkg;

    localparam logic [7:0] MARKER_DEFAULT = 8'h9E;

    typedef enum logic {
        CH_IDLE     = 1'b0,
        CH_IN_FRAME = 1'b1
    } ch_state_t;

    typedef enum logic {
        RDY_ALWAYS = 1'b0,
        RDY_OSC    = 1'b1
    } rdy_mode_t;

    function automatic logic [3:0] nz4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/axis_ready_osc.sv
// ---------------------------------------------------------------------------
// axis_ready_osc
// Generates the stream tready. In always-ready mode tready is high from the
// first clock after reset. In oscillating mode tready is high for rdy_high
// cycles, then low for rdy_low cycles, repeating regardless of tvalid.
// Ports:
//   aclk, aresetn      - clock, asynchronous active-low reset
//   mode               - 0 = always ready, 1 = oscillating
//   rdy_high, rdy_low  - phase lengths in cycles (0 behaves as 1)
//   tready             - generated ready
// ---------------------------------------------------------------------------
module axis_ready_osc
    import axis_chk_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       mode,
    input  logic [3:0] rdy_high,
    input  logic [3:0] rdy_low,
    output logic       tready
);

    logic       started_reg;
    logic       phase_high_reg;
    logic [3:0] cnt_reg;
    logic [3:0] len_reg;

    // The length of a phase is captured when the phase begins, so a config
    // change only shows up at the next boundary. Outside oscillating mode the
    // generator parks at the start of its high phase, so switching into
    // oscillating mode always begins with a full high phase.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            started_reg    <= 1'b0;
            phase_high_reg <= 1'b1;
            cnt_reg        <= 4'd0;
            len_reg        <= 4'd1;
        end else begin
            started_reg <= 1'b1;
            if (!started_reg || rdy_mode_t'(mode) == RDY_ALWAYS) begin
                phase_high_reg <= 1'b1;
                cnt_reg        <= 4'd0;
                len_reg        <= nz4(rdy_high);
            end else if (cnt_reg == len_reg - 4'd1) begin
                phase_high_reg <= !phase_high_reg;
                cnt_reg        <= 4'd0;
                len_reg        <= phase_high_reg ? nz4(rdy_low) : nz4(rdy_high);
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign tready = started_reg && (rdy_mode_t'(mode) == RDY_ALWAYS || phase_high_reg);

endmodule

// File: rtl/axis_frame_checker.sv
// ---------------------------------------------------------------------------
// axis_frame_checker
// Checks AXI-Stream frames on N_CH interleaved channels (selected by tdest).
// Even beat k carries (k/2) mod 256 in byte 0, odd beats carry MARKER, all
// other bytes are zero, and a frame is cfg_len beats long. Per channel it
// counts completed frames (wrapping) and errored frames (saturating).
// Ports:
//   aclk, aresetn            - clock, asynchronous active-low reset
//   s_axis_*                 - AXI-Stream slave (tready from axis_ready_osc)
//   cfg_len                  - expected beats per frame (0 behaves as 1)
//   cfg_rdy_mode/high/low    - ready generator configuration
//   clr                      - synchronous clear of counters and channel state
//   frame_cnt, err_cnt       - packed per-channel counters, channel 0 in LSBs
//   frame_done, frame_err    - one-cycle pulse the cycle after a tlast beat
//   done_ch                  - channel of the most recent frame_done
// ---------------------------------------------------------------------------
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int         DATA_BYTES = 64,
    parameter int         N_CH       = 4,
    parameter int         CNT_W      = 16,
    parameter logic [7:0] MARKER     = MARKER_DEFAULT,
    localparam int        DEST_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [DEST_W-1:0]       s_axis_tdest,
    input  logic [15:0]             cfg_len,
    input  logic                    cfg_rdy_mode,
    input  logic [3:0]              cfg_rdy_high,
    input  logic [3:0]              cfg_rdy_low,
    input  logic                    clr,
    output logic [N_CH*CNT_W-1:0]   frame_cnt,
    output logic [N_CH*CNT_W-1:0]   err_cnt,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [DEST_W-1:0]       done_ch
);

    ch_state_t          state_reg     [N_CH];
    logic [15:0]        k_reg         [N_CH];
    logic               flag_reg      [N_CH];
    logic [CNT_W-1:0]   frame_cnt_reg [N_CH];
    logic [CNT_W-1:0]   err_cnt_reg   [N_CH];
    logic               frame_done_reg;
    logic               frame_err_reg;
    logic [DEST_W-1:0]  done_ch_reg;

    axis_ready_osc u_ready (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .mode     (cfg_rdy_mode),
        .rdy_high (cfg_rdy_high),
        .rdy_low  (cfg_rdy_low),
        .tready   (s_axis_tready)
    );

    // Evaluation of the beat against the addressed channel's state.
    logic        hit;
    logic [15:0] len_eff;
    logic [15:0] cur_k;
    logic [7:0]  exp_b0;
    logic        beat_bad;
    logic        frame_bad;
    ch_state_t   state_next;
    logic [15:0] k_next;
    logic        flag_next;

    always_comb begin
        hit        = 1'b0;
        len_eff    = (cfg_len == 16'd0) ? 16'd1 : cfg_len;
        cur_k      = 16'd0;
        exp_b0     = 8'd0;
        beat_bad   = 1'b0;
        frame_bad  = 1'b0;
        state_next = CH_IDLE;
        k_next     = 16'd0;
        flag_next  = 1'b0;
        // Out-of-range tdest beats are still handshaken but never counted.
        if (s_axis_tvalid && s_axis_tready && int'(s_axis_tdest) < N_CH) begin
            hit        = 1'b1;
            cur_k      = k_reg[s_axis_tdest];
            state_next = state_reg[s_axis_tdest];
            exp_b0     = cur_k[0] ? MARKER : cur_k[8:1];
            beat_bad   = (s_axis_tdata[7:0] != exp_b0) || (|(s_axis_tdata >> 8));
            // Short frame: tlast before the last expected beat.
            // Long frame: the last expected beat arrives without tlast.
            if (s_axis_tlast)
                beat_bad = beat_bad || (cur_k < len_eff - 16'd1);
            else
                beat_bad = beat_bad || (cur_k == len_eff - 16'd1);
            frame_bad = flag_reg[s_axis_tdest] || beat_bad;
            if (s_axis_tlast) begin
                state_next = CH_IDLE;
                k_next     = 16'd0;
                flag_next  = 1'b0;
            end else begin
                state_next = CH_IN_FRAME;
                k_next     = cur_k + 16'd1;
                flag_next  = frame_bad;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CH; i++) begin
                state_reg[i]     <= CH_IDLE;
                k_reg[i]         <= 16'd0;
                flag_reg[i]      <= 1'b0;
                frame_cnt_reg[i] <= '0;
                err_cnt_reg[i]   <= '0;
            end
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            done_ch_reg    <= '0;
        end else if (clr) begin
            // clr wins over a simultaneous handshake: that beat is dropped.
            for (int i = 0; i < N_CH; i++) begin
                state_reg[i]     <= CH_IDLE;
                k_reg[i]         <= 16'd0;
                flag_reg[i]      <= 1'b0;
                frame_cnt_reg[i] <= '0;
                err_cnt_reg[i]   <= '0;
            end
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            done_ch_reg    <= '0;
        end else begin
            frame_done_reg <= hit && s_axis_tlast;
            frame_err_reg  <= hit && s_axis_tlast && frame_bad;
            if (hit) begin
                state_reg[s_axis_tdest] <= state_next;
                k_reg[s_axis_tdest]     <= k_next;
                flag_reg[s_axis_tdest]  <= flag_next;
                if (s_axis_tlast) begin
                    done_ch_reg <= s_axis_tdest;
                    frame_cnt_reg[s_axis_tdest] <= frame_cnt_reg[s_axis_tdest] + CNT_W'(1);
                    if (frame_bad && err_cnt_reg[s_axis_tdest] != '1)
                        err_cnt_reg[s_axis_tdest] <= err_cnt_reg[s_axis_tdest] + CNT_W'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_pack
            assign frame_cnt[gi*CNT_W +: CNT_W] = frame_cnt_reg[gi];
            assign err_cnt[gi*CNT_W +: CNT_W]   = err_cnt_reg[gi];
        end
    endgenerate

    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign done_ch    = done_ch_reg;

endmodule

// File: tb/tb_axis_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_checker
// Directed and randomized stimulus for axis_frame_checker. The reference
// model keeps the beats of each open frame and judges a whole frame when its
// tlast arrives: the frame is in error if its length differs from cfg_len or
// any beat's payload differs from the pattern for its position.
// ---------------------------------------------------------------------------
module tb_axis_frame_checker;

    localparam int DB  = 64;
    localparam int NCH = 3;
    localparam int CW  = 4;
    localparam int DW  = 2;
    localparam logic [7:0] MK = 8'h9E;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [8*DB-1:0]   s_axis_tdata;
    logic              s_axis_tlast;
    logic [DW-1:0]     s_axis_tdest;
    logic [15:0]       cfg_len;
    logic              cfg_rdy_mode;
    logic [3:0]        cfg_rdy_high;
    logic [3:0]        cfg_rdy_low;
    logic              clr;
    logic [NCH*CW-1:0] frame_cnt;
    logic [NCH*CW-1:0] err_cnt;
    logic              frame_done;
    logic              frame_err;
    logic [DW-1:0]     done_ch;

    axis_frame_checker #(
        .DATA_BYTES (DB),
        .N_CH       (NCH),
        .CNT_W      (CW),
        .MARKER     (MK)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .cfg_len       (cfg_len),
        .cfg_rdy_mode  (cfg_rdy_mode),
        .cfg_rdy_high  (cfg_rdy_high),
        .cfg_rdy_low   (cfg_rdy_low),
        .clr           (clr),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .done_ch       (done_ch)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ch;
        logic [7:0] b0;
        bit         upnz;
    } beat_t;

    beat_t hist[$];
    int    exp_fc [NCH];
    int    exp_ec [NCH];
    int    hs_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] want_b0(input int i);
        logic [7:0] v;
        v = (i % 2 == 1) ? MK : 8'((i / 2) % 256);
        return v;
    endfunction

    function automatic logic [CW-1:0] fc_of(input int ch);
        return frame_cnt[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] ec_of(input int ch);
        return err_cnt[ch*CW +: CW];
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int c = 0; c < NCH; c++) begin
            exp_fc[c] = 0;
            exp_ec[c] = 0;
        end
    endtask

    // Records an accepted beat; on tlast judges the whole frame.
    task automatic model_accept(input int ch, input logic [7:0] b0, input bit upnz,
                                input bit last, output bit done, output bit ferr);
        beat_t keep[$];
        int    n;
        bit    bad;
        int    len_eff;
        done = 0;
        ferr = 0;
        if (ch >= NCH) return;
        hist.push_back('{ch: ch, b0: b0, upnz: upnz});
        if (!last) return;
        len_eff = (cfg_len == 0) ? 1 : int'(cfg_len);
        n   = 0;
        bad = 0;
        foreach (hist[j]) begin
            if (hist[j].ch == ch) begin
                if (hist[j].upnz || hist[j].b0 != want_b0(n)) bad = 1;
                n++;
            end else begin
                keep.push_back(hist[j]);
            end
        end
        hist = keep;
        ferr = bad || (n != len_eff);
        exp_fc[ch] = (exp_fc[ch] + 1) % (1 << CW);
        if (ferr && exp_ec[ch] < (1 << CW) - 1) exp_ec[ch]++;
        done = 1;
    endtask

    // Presents one beat, waits (bounded) for the handshake, then checks the
    // frame_done pulse and counters in the following cycle.
    task automatic send(input int ch, input logic [7:0] b0, input bit upnz, input bit last);
        logic [8*DB-1:0] d;
        int g;
        bit done, ferr;
        d = '0;
        d[7:0] = b0;
        if (upnz) d[$urandom_range(8, 8*DB-1)] = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tdest  = DW'(ch);
        s_axis_tlast  = last;
        g = 0;
        while (!s_axis_tready && g < 64) begin
            @(negedge aclk);
            g++;
        end
        if (g >= 64) begin
            chk("ready_timeout", 32'(s_axis_tready), 32'd1);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        hs_cyc = cyc;
        model_accept(ch, b0, upnz, last, done, ferr);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("frame_done", 32'(frame_done), 32'(done));
        if (done) begin
            $display("frame ch=%0d err=%0d frame_cnt=%0d err_cnt=%0d", ch, ferr, fc_of(ch), ec_of(ch));
            chk("done_ch", 32'(done_ch), 32'(ch));
            chk("frame_err", 32'(frame_err), 32'(ferr));
            chk("frame_cnt", 32'(fc_of(ch)), 32'(exp_fc[ch]));
            chk("err_cnt", 32'(ec_of(ch)), 32'(exp_ec[ch]));
        end
    endtask

    task automatic send_frame(input int ch, input int nbeats, input int bad_idx);
        for (int i = 0; i < nbeats; i++)
            send(ch, (i == bad_idx) ? 8'h00 : want_b0(i), 1'b0, i == nbeats - 1);
    endtask

    task automatic do_clr();
        @(negedge aclk);
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        model_clear();
        chk("clr_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    endtask

    task automatic check_all_counts(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk({tag, "_fc"}, 32'(fc_of(c)), 32'(exp_fc[c]));
            chk({tag, "_ec"}, 32'(ec_of(c)), 32'(exp_ec[c]));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_done_ch", 32'(done_ch), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rel_tready_before_clk", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        chk("rel_tready_first_clk", 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        int t0, need, ilast;
        int tgt [NCH];
        int pos [NCH];
        int lenr;

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tdest  = '0;
        cfg_len       = 16'd24;
        cfg_rdy_mode  = 1'b0;
        cfg_rdy_high  = 4'd1;
        cfg_rdy_low   = 4'd1;
        clr           = 1'b0;
        model_clear();

        // Reset state, then release and check first tready timing.
        #1;
        check_reset_outputs();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("init_tready_before_clk", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        chk("init_tready_first_clk", 32'(s_axis_tready), 32'd1);

        // Clean 24-beat frame, then the same frame with beat 5 corrupted.
        send_frame(0, 24, -1);
        chk("clean_fc0", 32'(fc_of(0)), 32'd1);
        chk("clean_ec0", 32'(ec_of(0)), 32'd0);
        send_frame(0, 24, 5);
        chk("bad5_ec0", 32'(ec_of(0)), 32'd1);

        // Short frame (tlast on beat 10) followed by a clean frame.
        do_clr();
        send_frame(0, 11, -1);
        send_frame(0, 24, -1);
        chk("short_fc0", 32'(fc_of(0)), 32'd2);
        chk("short_ec0", 32'(ec_of(0)), 32'd1);

        // Long frame: tlast one beat late.
        send_frame(1, 25, -1);

        // Interleaved ch0/ch1 clean frames.
        do_clr();
        for (int i = 0; i < 24; i++) begin
            send(0, want_b0(i), 1'b0, i == 23);
            send(1, want_b0(i), 1'b0, i == 23);
        end
        chk("ilv_fc0", 32'(fc_of(0)), 32'd1);
        chk("ilv_fc1", 32'(fc_of(1)), 32'd1);

        // Out-of-range tdest is accepted and counted nowhere.
        send(3, 8'h00, 1'b0, 1'b1);
        send(3, 8'h55, 1'b1, 1'b0);
        check_all_counts("oor");

        // clr beats a simultaneous tlast handshake and resets open frames.
        do_clr();
        send(0, want_b0(0), 1'b0, 1'b0);
        send(0, want_b0(1), 1'b0, 1'b0);
        send(0, want_b0(2), 1'b0, 1'b0);
        @(negedge aclk);
        clr           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdest  = '0;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tdata[7:0] = want_b0(3);
        @(negedge aclk);
        clr           = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        model_clear();
        chk("clrprio_done", 32'(frame_done), 32'd0);
        chk("clrprio_fc0", 32'(fc_of(0)), 32'd0);
        send_frame(0, 24, -1);

        // Oscillating ready: high 6, low 2.
        @(negedge aclk);
        cfg_rdy_high = 4'd6;
        cfg_rdy_low  = 4'd2;
        @(negedge aclk);
        cfg_rdy_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("osc_ready", 32'(s_axis_tready), 32'((i % 8) < 6));
            @(negedge aclk);
        end
        t0 = cyc;
        need = 0;
        ilast = 0;
        for (int i = 0; i < 64; i++) begin
            if ((i % 8) < 6) need++;
            if (need == 24) begin
                ilast = i;
                break;
            end
        end
        send_frame(2, 24, -1);
        chk("osc_24_beats_cycles", 32'(hs_cyc - t0), 32'(ilast + 1));
        @(negedge aclk);
        cfg_rdy_mode = 1'b0;

        // Reset mid-frame after beat 7, then a clean frame.
        do_clr();
        for (int i = 0; i < 8; i++) send(0, want_b0(i), 1'b0, 1'b0);
        reset_pulse();
        send_frame(0, 24, -1);
        chk("rst_mid_fc0", 32'(fc_of(0)), 32'd1);
        chk("rst_mid_ec0", 32'(ec_of(0)), 32'd0);

        // Counter boundaries: 17 short one-beat frames (cfg_len=2).
        do_clr();
        cfg_len = 16'd2;
        for (int i = 0; i < 17; i++) send(2, 8'h00, 1'b0, 1'b1);
        chk("wrap_fc2", 32'(fc_of(2)), 32'd1);
        chk("sat_ec2", 32'(ec_of(2)), 32'd15);

        // cfg_len = 0 behaves as 1.
        cfg_len = 16'd0;
        send(1, 8'h00, 1'b0, 1'b1);

        // Randomized interleaved traffic under oscillating ready.
        do_clr();
        lenr = $urandom_range(3, 8);
        cfg_len = 16'(lenr);
        cfg_rdy_high = 4'($urandom_range(0, 5));
        cfg_rdy_low  = 4'($urandom_range(0, 3));
        cfg_rdy_mode = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            pos[c] = 0;
            tgt[c] = lenr - 2 + $urandom_range(0, 3);
        end
        for (int n = 0; n < 300; n++) begin
            int ch;
            bit last;
            logic [7:0] b0;
            if ($urandom_range(0, 9) == 0) begin
                send(3, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                ch = $urandom_range(0, NCH - 1);
                b0 = ($urandom_range(0, 15) == 0) ? 8'($urandom) : want_b0(pos[ch]);
                last = (pos[ch] + 1 >= tgt[ch]);
                send(ch, b0, $urandom_range(0, 40) == 0, last);
                if (last) begin
                    pos[ch] = 0;
                    tgt[ch] = lenr - 2 + $urandom_range(0, 3);
                end else begin
                    pos[ch]++;
                end
            end
            if (n % 50 == 25) begin
                cfg_rdy_high = 4'($urandom_range(0, 5));
                cfg_rdy_low  = 4'($urandom_range(0, 3));
            end
        end
        check_all_counts("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
